// File: rtl/axis_eth_rx_fcs_fifo.sv
// Store-and-forward receive FIFO: strips the 4-byte FCS, drops runt/bad/overflowed frames and
// releases only whole committed frames to a backpressured AXI stream.
module axis_eth_rx_fcs_fifo #(
  parameter int unsigned DEPTH          = 4096,
  parameter bit          DROP_BAD_FRAME = 1'b1,
  parameter int unsigned ADDR_W         = $clog2(DEPTH)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] s_axis_tdata,
  input  logic       s_axis_tvalid,
  input  logic       s_axis_tlast,
  input  logic       s_axis_tuser,
  output logic [7:0] m_axis_tdata,
  output logic       m_axis_tvalid,
  input  logic       m_axis_tready,
  output logic       m_axis_tlast,
  output logic       m_axis_tuser,
  output logic       status_good_frame,
  output logic       status_bad_frame,
  output logic       status_overflow,
  output logic       status_runt
);

  typedef logic [ADDR_W:0] ptr_t;
  localparam ptr_t FullCount = ptr_t'(DEPTH);

  logic [8:0] mem      [DEPTH];
  logic       user_mem [DEPTH];

  logic [7:0] dly_q [4];
  logic [7:0] dly_d [4];
  logic [2:0] dcnt_q, dcnt_d;
  logic       ovf_q, ovf_d;
  ptr_t       wr_ptr_q, wr_ptr_d;
  ptr_t       wr_commit_q, wr_commit_d;
  ptr_t       rd_ptr_q, rd_ptr_d;

  logic       full, wr_en, wr_user;
  logic [8:0] wr_data;

  logic good_q, good_d, bad_q, bad_d, ovfst_q, ovfst_d, runt_q, runt_d;
  logic [7:0] m_data_q, m_data_d;
  logic       m_valid_q, m_valid_d, m_last_q, m_last_d, m_user_q, m_user_d;
  logic       load;

  // Write side: delay line, speculative writes and end-of-frame commit/rewind.
  always_comb begin
    dly_d       = dly_q;
    dcnt_d      = dcnt_q;
    ovf_d       = ovf_q;
    wr_ptr_d    = wr_ptr_q;
    wr_commit_d = wr_commit_q;
    wr_en       = 1'b0;
    wr_data     = {1'b0, dly_q[3]};
    wr_user     = 1'b0;
    good_d      = 1'b0;
    bad_d       = 1'b0;
    ovfst_d     = 1'b0;
    runt_d      = 1'b0;
    full        = ptr_t'(wr_ptr_q - rd_ptr_q) == FullCount;

    if (s_axis_tvalid) begin
      if (!s_axis_tlast) begin
        dly_d[0] = s_axis_tdata;
        for (int i = 1; i < 4; i++) dly_d[i] = dly_q[i-1];
        if (dcnt_q == 3'd4) begin
          if (full) begin
            ovf_d = 1'b1;
          end else if (!ovf_q) begin
            wr_en    = 1'b1;
            wr_ptr_d = wr_ptr_q + ptr_t'(1);
          end
        end else begin
          dcnt_d = dcnt_q + 3'd1;
        end
      end else begin
        dcnt_d  = 3'd0;
        ovf_d   = 1'b0;
        wr_data = {1'b1, dly_q[3]};
        wr_user = s_axis_tuser;
        if (dcnt_q != 3'd4) begin
          wr_ptr_d = wr_commit_q;
          runt_d   = 1'b1;
          bad_d    = s_axis_tuser;
        end else if (ovf_q || full) begin
          wr_ptr_d = wr_commit_q;
          ovfst_d  = 1'b1;
        end else if (s_axis_tuser && DROP_BAD_FRAME) begin
          wr_ptr_d = wr_commit_q;
          bad_d    = 1'b1;
        end else begin
          wr_en       = 1'b1;
          wr_ptr_d    = wr_ptr_q + ptr_t'(1);
          wr_commit_d = wr_ptr_q + ptr_t'(1);
          good_d      = !s_axis_tuser;
          bad_d       = s_axis_tuser;
        end
      end
    end
  end

  // Read side: single output register, refilled whenever empty or being consumed.
  always_comb begin
    rd_ptr_d  = rd_ptr_q;
    m_data_d  = m_data_q;
    m_last_d  = m_last_q;
    m_user_d  = m_user_q;
    m_valid_d = m_valid_q;
    load      = (rd_ptr_q != wr_commit_q) && (!m_valid_q || m_axis_tready);
    if (load) begin
      m_data_d  = mem[rd_ptr_q[ADDR_W-1:0]][7:0];
      m_last_d  = mem[rd_ptr_q[ADDR_W-1:0]][8];
      m_user_d  = user_mem[rd_ptr_q[ADDR_W-1:0]];
      m_valid_d = 1'b1;
      rd_ptr_d  = rd_ptr_q + ptr_t'(1);
    end else if (m_axis_tready) begin
      m_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr_q[ADDR_W-1:0]]      <= wr_data;
      user_mem[wr_ptr_q[ADDR_W-1:0]] <= wr_user;
    end
  end

  always_ff @(posedge clk) begin
    dly_q <= dly_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dcnt_q      <= 3'd0;
      ovf_q       <= 1'b0;
      wr_ptr_q    <= '0;
      wr_commit_q <= '0;
      rd_ptr_q    <= '0;
      good_q      <= 1'b0;
      bad_q       <= 1'b0;
      ovfst_q     <= 1'b0;
      runt_q      <= 1'b0;
      m_data_q    <= 8'd0;
      m_valid_q   <= 1'b0;
      m_last_q    <= 1'b0;
      m_user_q    <= 1'b0;
    end else begin
      dcnt_q      <= dcnt_d;
      ovf_q       <= ovf_d;
      wr_ptr_q    <= wr_ptr_d;
      wr_commit_q <= wr_commit_d;
      rd_ptr_q    <= rd_ptr_d;
      good_q      <= good_d;
      bad_q       <= bad_d;
      ovfst_q     <= ovfst_d;
      runt_q      <= runt_d;
      m_data_q    <= m_data_d;
      m_valid_q   <= m_valid_d;
      m_last_q    <= m_last_d;
      m_user_q    <= m_user_d;
    end
  end

  assign m_axis_tdata      = m_data_q;
  assign m_axis_tvalid     = m_valid_q;
  assign m_axis_tlast      = m_last_q;
  assign m_axis_tuser      = m_user_q;
  assign status_good_frame = good_q;
  assign status_bad_frame  = bad_q;
  assign status_overflow   = ovfst_q;
  assign status_runt       = runt_q;

endmodule
